// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, load formatter and writeback select for RV32I.
// Also keeps the retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic [1:0]       in_wb_sel,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_mem_rdata,
    input  logic [2:0]       in_funct3,
    output logic [4:0]       w_addr,
    output logic [XLEN-1:0]  w_data,
    output logic             w_en,
    output logic             wb_valid,
    output logic             load_fault,
    output logic [CNT_W-1:0] retired
);

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic            reg_write;
        logic [1:0]      wb_sel;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rdata;
        logic [2:0]      funct3;
    } mw_t;

    mw_t              st_q, st_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic [1:0]       off;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [XLEN-1:0]  ld_data;
    logic             ld_bad;

    always_comb begin
        st_d = st_q;
        if (flush) begin
            st_d = '0;
        end else if (!stall) begin
            st_d = '{valid:     in_valid,
                     rd:        in_rd,
                     reg_write: in_reg_write,
                     wb_sel:    in_wb_sel,
                     alu:       in_alu_result,
                     pc4:       in_pc_plus4,
                     imm:       in_imm,
                     rdata:     in_mem_rdata,
                     funct3:    in_funct3};
        end
    end

    // The instruction in WB leaves the stage unless the stage is held.
    always_comb begin
        ret_d = ret_q;
        if (st_q.valid && (flush || !stall))
            ret_d = ret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '0;
            ret_q <= '0;
        end else begin
            st_q  <= st_d;
            ret_q <= ret_d;
        end
    end

    assign off  = st_q.alu[1:0];
    assign ld_b = st_q.rdata[{off, 3'b000} +: 8];
    assign ld_h = st_q.rdata[{off[1], 4'b0000} +: 16];

    // Faulting loads pass the raw word through; the write is blocked below.
    always_comb begin
        ld_data = st_q.rdata;
        ld_bad  = 1'b0;
        unique case (st_q.funct3)
            3'b000: ld_data = {{(XLEN-8){ld_b[7]}}, ld_b};
            3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_b};
            3'b001, 3'b101: begin
                if (off[0])
                    ld_bad = 1'b1;
                else
                    ld_data = {{(XLEN-16){ld_h[15] & ~st_q.funct3[2]}}, ld_h};
            end
            3'b010:  ld_bad = |off;
            default: ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_data = st_q.alu;
        unique case (st_q.wb_sel)
            2'b00: w_data = st_q.alu;
            2'b01: w_data = ld_data;
            2'b10: w_data = st_q.pc4;
            2'b11: w_data = st_q.imm;
        endcase
    end

    assign wb_valid   = st_q.valid;
    assign load_fault = st_q.valid & (st_q.wb_sel == 2'b01) & ld_bad;
    assign w_addr     = st_q.rd;
    assign w_en       = st_q.valid & st_q.reg_write & (|st_q.rd) & ~load_fault;
    assign retired    = ret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a reference model predicts outputs
// per cycle; a narrow-counter instance checks retired wraparound.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic [1:0]  in_wb_sel = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic [31:0] in_imm = '0;
    logic [31:0] in_mem_rdata = '0;
    logic [2:0]  in_funct3 = '0;

    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        wb_valid;
    logic        load_fault;
    logic [31:0] retired;

    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic        s_en;
    logic        s_valid;
    logic        s_fault;
    logic [2:0]  s_retired;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .stall(stall), .flush(flush), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .in_imm(in_imm), .in_mem_rdata(in_mem_rdata),
        .in_funct3(in_funct3), .w_addr(w_addr), .w_data(w_data),
        .w_en(w_en), .wb_valid(wb_valid), .load_fault(load_fault),
        .retired(retired)
    );

    mem_wb_stage #(.XLEN(32), .CNT_W(3)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .stall(stall), .flush(flush), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .in_imm(in_imm), .in_mem_rdata(in_mem_rdata),
        .in_funct3(in_funct3), .w_addr(s_addr), .w_data(s_data),
        .w_en(s_en), .wb_valid(s_valid), .load_fault(s_fault),
        .retired(s_retired)
    );

    typedef struct {
        logic        wbv;
        logic        wen;
        logic        lf;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] ret;
        logic [2:0]  ret3;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    logic        m_valid, m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [31:0] m_alu, m_pc4, m_imm, m_rdata;
    logic [2:0]  m_f3;
    logic [31:0] m_cnt;
    logic [2:0]  m_cnt3;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Returns {fault, data} for a load of the given code and byte offset.
    function automatic logic [32:0] fmt(logic [2:0] f3, logic [1:0] o,
                                        logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] hw;
        sh = rd >> (o * 8);
        hw = o[1] ? (rd >> 16) : rd;
        case (f3)
            3'd0: return {1'b0, 32'($signed(sh[7:0]))};
            3'd4: return {1'b0, 24'h0, sh[7:0]};
            3'd1: return o[0] ? {1'b1, rd} : {1'b0, 32'($signed(hw[15:0]))};
            3'd5: return o[0] ? {1'b1, rd} : {1'b0, 16'h0, hw[15:0]};
            3'd2: return {(o != 2'd0), rd};
            default: return {1'b1, rd};
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic [32:0] f;
        f      = fmt(m_f3, m_alu[1:0], m_rdata);
        e.wbv  = m_valid;
        e.lf   = m_valid && m_sel == 2'd1 && f[32];
        e.addr = m_rd;
        case (m_sel)
            2'd0: e.data = m_alu;
            2'd1: e.data = f[31:0];
            2'd2: e.data = m_pc4;
            default: e.data = m_imm;
        endcase
        e.wen  = m_valid && m_rw && m_rd != 5'd0 && !e.lf;
        e.ret  = m_cnt;
        e.ret3 = m_cnt3;
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0;
        m_alu = 0; m_pc4 = 0; m_imm = 0; m_rdata = 0; m_f3 = 0;
        m_cnt = 0; m_cnt3 = 0;
    endtask

    task automatic compare(string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_valid"}, 32'(wb_valid), 32'(e.wbv));
        chk({tag, "_wen"}, 32'(w_en), 32'(e.wen));
        chk({tag, "_fault"}, 32'(load_fault), 32'(e.lf));
        chk({tag, "_addr"}, 32'(w_addr), 32'(e.addr));
        chk({tag, "_data"}, w_data, e.data);
        chk({tag, "_ret"}, retired, e.ret);
        chk({tag, "_ret3"}, 32'(s_retired), 32'(e.ret3));
    endtask

    // Called just after a negedge: drive, predict, clock, compare.
    task automatic step(string tag, logic v, logic st, logic fl,
                        logic [4:0] rd, logic rw, logic [1:0] sel,
                        logic [31:0] alu, logic [31:0] pc4,
                        logic [31:0] imm, logic [31:0] rdat,
                        logic [2:0] f3);
        in_valid = v; stall = st; flush = fl; in_rd = rd;
        in_reg_write = rw; in_wb_sel = sel; in_alu_result = alu;
        in_pc_plus4 = pc4; in_imm = imm; in_mem_rdata = rdat;
        in_funct3 = f3;
        if (m_valid && (fl || !st)) begin
            m_cnt++;
            m_cnt3++;
        end
        if (fl) begin
            m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_alu = 0;
            m_pc4 = 0; m_imm = 0; m_rdata = 0; m_f3 = 0;
        end else if (!st) begin
            m_valid = v; m_rw = rw; m_rd = rd; m_sel = sel; m_alu = alu;
            m_pc4 = pc4; m_imm = imm; m_rdata = rdat; m_f3 = f3;
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        compare(tag);
    endtask

    task automatic alu_op(string tag, logic [4:0] rd, logic [31:0] val);
        step(tag, 1, 0, 0, rd, 1, 2'd0, val, 32'h0, 32'h0, 32'h0, 3'd2);
    endtask

    task automatic load(string tag, logic [4:0] rd, logic [2:0] f3,
                        logic [1:0] o, logic [31:0] rdat);
        step(tag, 1, 0, 0, rd, 1, 2'd1, {30'h40, o}, 32'h0, 32'h0,
             rdat, f3);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        exp_q.push_back(model_out());
        compare("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            alu_op("warm", 5'(i + 1), 32'h100 + 32'(i));

        // Asynchronous reset mid-run with a live instruction in WB.
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_out());
        compare("mid_rst");
        @(negedge clk);
        exp_q.push_back(model_out());
        compare("rst_hold");
        rst_n = 1'b1;

        load("lb", 5'd3, 3'd0, 2'd3, 32'h80FF7F01);
        load("lbu", 5'd3, 3'd4, 2'd3, 32'h80FF7F01);
        load("lb1", 5'd7, 3'd0, 2'd1, 32'h80FF7F01);
        load("lh2", 5'd4, 3'd1, 2'd2, 32'h80FF7F01);
        load("lhu2", 5'd4, 3'd5, 2'd2, 32'h80FF7F01);
        load("lh0", 5'd4, 3'd1, 2'd0, 32'h1234F00D);
        load("lw", 5'd9, 3'd2, 2'd0, 32'hDEADBEEF);
        load("lh_mis", 5'd6, 3'd1, 2'd1, 32'hCAFEBABE);
        load("lw_mis", 5'd6, 3'd2, 2'd2, 32'hCAFEBABE);
        load("ill", 5'd6, 3'd3, 2'd0, 32'h0BADF00D);
        step("x0", 1, 0, 0, 5'd0, 1, 2'd0, 32'h55, 32'h0, 32'h0,
             32'h0, 3'd2);
        step("lui", 1, 0, 0, 5'd8, 1, 2'd3, 32'h0, 32'h0,
             32'hABCDE000, 32'h0, 3'd0);

        alu_op("alu5", 5'd5, 32'h1234);
        step("stall1", 1, 1, 0, 5'd1, 1, 2'd2, 32'h0, 32'h104,
             32'h0, 32'h0, 3'd0);
        step("stall2", 1, 1, 0, 5'd1, 1, 2'd2, 32'h0, 32'h104,
             32'h0, 32'h0, 3'd0);
        step("jal", 1, 0, 0, 5'd1, 1, 2'd2, 32'h0, 32'h104,
             32'h0, 32'h0, 3'd0);
        step("bubble", 0, 0, 0, 5'd0, 0, 2'd0, 32'h0, 32'h0,
             32'h0, 32'h0, 3'd0);
        step("fl_st", 1, 1, 1, 5'd2, 1, 2'd0, 32'h77, 32'h0,
             32'h0, 32'h0, 3'd2);
        alu_op("alu_a", 5'd10, 32'h99);
        step("flush", 1, 0, 1, 5'd11, 1, 2'd0, 32'h88, 32'h0,
             32'h0, 32'h0, 3'd2);

        for (int i = 0; i < 60; i++) begin
            logic fl, st;
            fl = ($urandom_range(0, 9) == 0);
            st = fl ? 1'b0 : ($urandom_range(0, 5) == 0);
            step("rnd", 1'($urandom), st, fl, 5'($urandom),
                 1'($urandom), 2'($urandom), $urandom, $urandom,
                 $urandom, $urandom, 3'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
